// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared types and constants for the UART frame receiver:
//               receiver state encoding, majority-sample offsets around the
//               bit centre, and a 3-input majority helper.
//               The PARITY state exists only when UART_RX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } rx_state_t;

    // The three samples of each bit sit on ticks OVERSAMPLE/2-EARLY,
    // OVERSAMPLE/2 and OVERSAMPLE/2+LATE.
    localparam int c_MAJ_OFS_EARLY = 1;
    localparam int c_MAJ_OFS_LATE  = 1;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Input conditioning for the UART receiver.
//               - 2-flop synchronizer on the asynchronous rx line (resets to
//                 the idle level 1 so no false start is seen after reset).
//               - Rising-edge detector on the registered DDS oversample clock,
//                 giving a one-clk os_tick per oversample period.
// Ports       : clk, rst       - system clock, synchronous active-high reset
//               i_dds_clk      - oversample clock, synchronous to clk
//               i_rx           - raw serial line
//               o_rx_s         - synchronized serial line
//               o_os_tick      - one-clk oversample strobe
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_dds_clk,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_os_tick
);

    logic [1:0] r_rx_sync;
    logic       r_dds;
    logic       r_dds_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_sync <= 2'b11;
            r_dds     <= 1'b0;
            r_dds_d   <= 1'b0;
        end else begin
            r_rx_sync <= {r_rx_sync[0], i_rx};
            r_dds     <= i_dds_clk;
            r_dds_d   <= r_dds;
        end
    end

    assign o_rx_s    = r_rx_sync[1];
    assign o_os_tick = r_dds & ~r_dds_d;

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_frame
// Description : Oversampling UART frame receiver with valid/ready output.
//               Each bit is decided by a majority of three samples around the
//               bit centre. Bad stop bit -> frame_err pulse (frame still
//               delivered). Frame completing while valid is held without
//               ready -> data overwritten, sticky overrun.
//               Optional even-parity bit enabled by macro UART_RX_PARITY_EN;
//               without it parity_err is tied low.
// Ports       : clk, rst        - system clock, synchronous active-high reset
//               dds_clk         - oversample clock (OVERSAMPLE x baud)
//               rx              - serial input, idle high
//               data/valid/ready- received word handshake
//               frame_err       - one-clk pulse, bad stop bit
//               parity_err      - one-clk pulse, parity mismatch
//               overrun         - sticky overrun flag
//               busy            - receiver not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dds_clk,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int c_TW = $clog2(OVERSAMPLE);
    localparam int c_BW = $clog2(DATA_BITS + 1);

    localparam logic [c_TW-1:0] c_TICK_EARLY = c_TW'(OVERSAMPLE/2 - c_MAJ_OFS_EARLY);
    localparam logic [c_TW-1:0] c_TICK_MID   = c_TW'(OVERSAMPLE/2);
    localparam logic [c_TW-1:0] c_TICK_LATE  = c_TW'(OVERSAMPLE/2 + c_MAJ_OFS_LATE);
    localparam logic [c_TW-1:0] c_TICK_LAST  = c_TW'(OVERSAMPLE - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST   = c_BW'(DATA_BITS - 1);

    logic                 w_rx_s;
    logic                 w_os_tick;
    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic [c_TW-1:0]      r_tick_cnt;
    logic [c_BW-1:0]      r_bit_cnt;
    logic [1:0]           r_samp;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 w_maj;
    logic                 w_at_late;
    logic                 w_at_last;
    logic                 w_load;
    logic                 w_shift_en;

    uart_rx_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .i_dds_clk (dds_clk),
        .i_rx      (rx),
        .o_rx_s    (w_rx_s),
        .o_os_tick (w_os_tick)
    );

    // The third sample is the live rx_s on the late tick, so the majority is
    // only meaningful when qualified by w_at_late.
    assign w_maj     = majority3({r_samp, w_rx_s});
    assign w_at_late = w_os_tick && (r_tick_cnt == c_TICK_LATE);
    assign w_at_last = w_os_tick && (r_tick_cnt == c_TICK_LAST);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_os_tick && !w_rx_s) w_state_nxt = S_START;
            S_START: begin
                if (w_at_late && w_maj)  w_state_nxt = S_IDLE;
                else if (w_at_last)      w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_at_last && (r_bit_cnt == c_BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY:    if (w_at_last) w_state_nxt = S_STOP;
`endif
            // Leave STOP right after the late sample so the next start edge
            // is caught even if the transmitter's stop bit is short.
            S_STOP:      if (w_at_late) w_state_nxt = w_maj ? S_IDLE : S_WAIT_IDLE;
            S_WAIT_IDLE: if (w_os_tick && w_rx_s) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        busy       = (r_state != S_IDLE);
        w_load     = 1'b0;
        w_shift_en = 1'b0;
        case (r_state)
            S_DATA:  w_shift_en = w_at_late;
            S_STOP:  w_load     = w_at_late;
            default: ;
        endcase
    end

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_samp      <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) || (r_state == S_WAIT_IDLE)) begin
                r_tick_cnt <= '0;
            end else if (w_os_tick) begin
                r_tick_cnt <= (r_tick_cnt == c_TICK_LAST) ? '0 : r_tick_cnt + c_TW'(1);
            end

            if (r_state != S_DATA) begin
                r_bit_cnt <= '0;
            end else if (w_at_last) begin
                r_bit_cnt <= r_bit_cnt + c_BW'(1);
            end

            if (w_os_tick && ((r_tick_cnt == c_TICK_EARLY) || (r_tick_cnt == c_TICK_MID))) begin
                r_samp <= {r_samp[0], w_rx_s};
            end

            // LSB arrives first, so shift in at the top and it ends up in bit 0.
            if (w_shift_en) begin
                r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
            end

            r_frame_err <= w_load && !w_maj;

            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                if (r_valid && !ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    logic r_parity_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            // Even parity: data bits XOR parity bit must be 0.
            if ((r_state == S_PARITY) && w_at_late) begin
                r_par_bad <= (^r_shift) ^ w_maj;
            end
            r_parity_err <= w_load && r_par_bad;
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_frame
// Description : Directed self-checking bench for uart_rx_frame with
//               OVERSAMPLE=16, DATA_BITS=8; dds_clk toggles every 4 clk so one
//               bit lasts 128 clk. Parity scenario compiled only when
//               UART_RX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame;

    localparam int c_BIT_CLK = 128;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dds_clk = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       ready = 1'b1;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor results
    int         hs_cnt = 0;
    logic [7:0] hs_data = 8'h00;
    int         fe_cnt = 0;
    int         pe_cnt = 0;
    int         pe_with_valid = 0;

`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_rx_frame #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dds_clk    (dds_clk),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (4) @(posedge clk);
            #1 dds_clk = ~dds_clk;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (valid && ready) begin
                hs_cnt  <= hs_cnt + 1;
                hs_data <= data;
            end
            if (frame_err) fe_cnt <= fe_cnt + 1;
            if (parity_err) begin
                pe_cnt <= pe_cnt + 1;
                if (valid) pe_with_valid <= pe_with_valid + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        #1 rx = v;
        repeat (c_BIT_CLK) @(posedge clk);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop_v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int hs0;
        int fe0;
        int wait_n;

        // ---- reset state
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("rst_data",       32'(data),       32'h00);
        check_eq("rst_valid",      32'(valid),      32'h0);
        check_eq("rst_frame_err",  32'(frame_err),  32'h0);
        check_eq("rst_parity_err", 32'(parity_err), 32'h0);
        check_eq("rst_overrun",    32'(overrun),    32'h0);
        check_eq("rst_busy",       32'(busy),       32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle_bits(2);

        // ---- 0xA5, good stop, ready=1
        hs0 = hs_cnt;
        send_frame(8'hA5, 1'b1);
        idle_bits(1);
        check_eq("a5_hs_count", 32'(hs_cnt - hs0), 32'd1);
        check_eq("a5_data",     32'(hs_data),      32'hA5);
        check_eq("a5_frame_err",32'(fe_cnt),       32'd0);
        check_eq("a5_overrun",  32'(overrun),      32'h0);
        check_eq("a5_valid_clr",32'(valid),        32'h0);

        // ---- false start: 3 ticks low
        hs0 = hs_cnt;
        #1 rx = 1'b0;
        repeat (24) @(posedge clk);
        #1 rx = 1'b1;
        wait_n = 0;
        @(negedge clk);
        while (busy && wait_n < 72) begin
            @(negedge clk);
            wait_n++;
        end
        check_eq("false_start_busy", 32'(busy), 32'h0);
        idle_bits(2);
        check_eq("false_start_no_valid", 32'(hs_cnt - hs0), 32'd0);

        // ---- 0x3C with bad stop, then 0x81
        hs0 = hs_cnt;
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        idle_bits(2);
        check_eq("3c_frame_err_pulses", 32'(fe_cnt - fe0), 32'd1);
        check_eq("3c_hs_count",         32'(hs_cnt - hs0), 32'd1);
        check_eq("3c_data",             32'(hs_data),      32'h3C);
        send_frame(8'h81, 1'b1);
        idle_bits(1);
        check_eq("81_data",      32'(hs_data),      32'h81);
        check_eq("81_no_fe",     32'(fe_cnt - fe0), 32'd1);

        // ---- overrun with ready=0
        #1 ready = 1'b0;
        send_frame(8'h11, 1'b1);
        idle_bits(1);
        send_frame(8'h22, 1'b1);
        idle_bits(1);
        @(negedge clk);
        check_eq("ovr_valid",   32'(valid),   32'h1);
        check_eq("ovr_data",    32'(data),    32'h22);
        check_eq("ovr_overrun", 32'(overrun), 32'h1);
        @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("ovr_valid_clr", 32'(valid),   32'h0);
        check_eq("ovr_sticky",    32'(overrun), 32'h1);
        check_eq("ovr_hs_data",   32'(hs_data), 32'h22);

        // ---- reset during bit 4 of 0x55, then 0x99
        hs0 = hs_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0] ? 1'b0 : 1'b1);
        #1 rx = 1'b1;
        repeat (64) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_busy",    32'(busy),    32'h0);
        check_eq("midrst_valid",   32'(valid),   32'h0);
        check_eq("midrst_overrun", 32'(overrun), 32'h0);
        idle_bits(6);
        check_eq("midrst_no_frame", 32'(hs_cnt - hs0), 32'd0);
        send_frame(8'h99, 1'b1);
        idle_bits(1);
        check_eq("99_hs_count", 32'(hs_cnt - hs0), 32'd1);
        check_eq("99_data",     32'(hs_data),      32'h99);

`ifdef UART_RX_PARITY_EN
        // ---- 0x07 with wrong (zero) parity bit
        hs0 = hs_cnt;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        idle_bits(1);
        check_eq("par_err_pulses",   32'(pe_cnt),        32'd1);
        check_eq("par_err_on_valid", 32'(pe_with_valid), 32'd1);
        check_eq("par_data",         32'(hs_data),       32'h07);
        check_eq("par_hs_count",     32'(hs_cnt - hs0),  32'd1);
`else
        check_eq("no_parity_err", 32'(pe_cnt), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
